gpu_color_modulate: RTL and testbench

//  Per-pixel RGB texture/vertex colour modulation stage of the GPU pixel pipeline.

---
 rtl/gpu_color_modulate_if.sv | 26 ++
 rtl/gpu_color_modulate.sv | 90 +++++++++
 tb/tb_gpu_color_modulate.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_color_modulate_if.sv
// Pixel stream bundle for the colour modulation stage: texel/vertex input side and modulated output side.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// valid and payload must hold until that edge, and ready may depend on the receiver's state only.
interface gpu_color_modulate_if #(
    parameter int CW   = 8,
    parameter int OUTW = 9
);
    logic              i_valid;
    logic              o_ready;
    logic [3*CW-1:0]   i_tex;
    logic [3*CW-1:0]   i_vtx;
    logic              i_rawTex;
    logic              o_valid;
    logic              i_ready;
    logic [3*OUTW-1:0] o_col;

    modport master (
        output i_valid, i_tex, i_vtx, i_rawTex, i_ready,
        input  o_ready, o_valid, o_col
    );

    modport slave (
        input  i_valid, i_tex, i_vtx, i_rawTex, i_ready,
        output o_ready, o_valid, o_col
    );
endinterface

// File: rtl/gpu_color_modulate.sv
// Two-stage RGB texture x vertex colour modulation: S1 registers operands, S2 registers the
// per-channel (tex*vtx)>>SHIFT (or raw texel) result. One pixel per clock, bubbles collapse.
module gpu_color_modulate #(
    parameter int CW    = 8,
    parameter int OUTW  = 9,
    parameter int SHIFT = 7
) (
    input  logic                 clk,
    input  logic                 i_rst,
    gpu_color_modulate_if.slave  bus,
    output logic                 o_busy
);
    logic            s1_valid_q, s1_valid_d;
    logic [3*CW-1:0] s1_tex_q,   s1_tex_d;
    logic [3*CW-1:0] s1_vtx_q,   s1_vtx_d;
    logic            s1_raw_q,   s1_raw_d;

    logic              s2_valid_q, s2_valid_d;
    logic [3*OUTW-1:0] s2_col_q,   s2_col_d;

    logic              advance1;
    logic              advance2;
    logic [3*OUTW-1:0] mod_col;

    // An empty stage always advances, so a stalled output only blocks input when both stages are full.
    assign advance2 = !s2_valid_q || bus.i_ready;
    assign advance1 = !s1_valid_q || advance2;

    assign bus.o_ready = advance1;
    assign bus.o_valid = s2_valid_q;
    assign bus.o_col   = s2_col_q;
    assign o_busy      = s1_valid_q || s2_valid_q;

    always_comb begin
        logic [2*CW-1:0] prod;
        mod_col = '0;
        prod    = '0;
        for (int c = 0; c < 3; c++) begin
            prod = s1_tex_q[c*CW +: CW] * s1_vtx_q[c*CW +: CW];
            if (s1_raw_q) begin
                mod_col[c*OUTW +: OUTW] = OUTW'(s1_tex_q[c*CW +: CW]);
            end else begin
                mod_col[c*OUTW +: OUTW] = OUTW'(prod >> SHIFT);
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tex_d   = s1_tex_q;
        s1_vtx_d   = s1_vtx_q;
        s1_raw_d   = s1_raw_q;
        s2_valid_d = s2_valid_q;
        s2_col_d   = s2_col_q;

        if (advance1) begin
            s1_valid_d = bus.i_valid;
            if (bus.i_valid) begin
                s1_tex_d = bus.i_tex;
                s1_vtx_d = bus.i_vtx;
                s1_raw_d = bus.i_rawTex;
            end
        end

        if (advance2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_col_d = mod_col;
            end
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_tex_q   <= '0;
            s1_vtx_q   <= '0;
            s1_raw_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_col_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tex_q   <= s1_tex_d;
            s1_vtx_q   <= s1_vtx_d;
            s1_raw_q   <= s1_raw_d;
            s2_valid_q <= s2_valid_d;
            s2_col_q   <= s2_col_d;
        end
    end
endmodule

// File: tb/tb_gpu_color_modulate.sv
// Self-checking bench for gpu_color_modulate: directed corner pixels, stalls, streaming,
// random traffic and mid-stream reset, checked through an expected-result queue.
module tb_gpu_color_modulate;
    localparam int CW    = 8;
    localparam int OUTW  = 9;
    localparam int SHIFT = 7;
    localparam int DW    = 3*CW;
    localparam int RW    = 3*OUTW;

    logic clk = 1'b0;
    logic i_rst;
    logic o_busy;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpu_color_modulate_if #(.CW(CW), .OUTW(OUTW)) bus ();

    gpu_color_modulate #(.CW(CW), .OUTW(OUTW), .SHIFT(SHIFT)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus),
        .o_busy(o_busy)
    );

    logic [RW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    logic          mon_en = 1'b0;
    logic          stall_prev = 1'b0;
    logic [RW-1:0] last_col = '0;
    int            run_len = 0;
    int            max_run = 0;
    int            first_valid_cyc = -1;
    int            accept_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [DW-1:0] tex, input logic [DW-1:0] vtx,
                                            input logic raw);
        logic [RW-1:0]   r;
        logic [CW-1:0]   t;
        logic [CW-1:0]   v;
        logic [2*CW-1:0] p;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            t = tex[c*CW +: CW];
            v = vtx[c*CW +: CW];
            p = t * v;
            r[c*OUTW +: OUTW] = raw ? {1'b0, t} : p[2*CW-1:SHIFT];
        end
        return r;
    endfunction

    // Scoreboard: occupancy checks, hold-under-stall checks, in-order result comparison.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", o_busy, exp_q.size() != 0);
            check("ready", bus.o_ready, (exp_q.size() < 2) || bus.i_ready);
            if (stall_prev) begin
                check("hold_valid", bus.o_valid, 1'b1);
                check("hold_col", bus.o_col, last_col);
            end
            if (bus.o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.o_valid && bus.i_ready) begin
                check("out_has_expect", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("col", bus.o_col, exp_q.pop_front());
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            stall_prev = bus.o_valid && !bus.i_ready;
            last_col   = bus.o_col;
        end
    end

    // Caller is just after a rising edge; returns just after the edge that accepted the pixel.
    task automatic send(input logic [DW-1:0] tex, input logic [DW-1:0] vtx, input logic raw,
                        input logic [RW-1:0] expv);
        int n;
        n = 0;
        bus.i_valid  = 1'b1;
        bus.i_tex    = tex;
        bus.i_vtx    = vtx;
        bus.i_rawTex = raw;
        @(negedge clk);
        while (!bus.o_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", n < 200, 1'b1);
        accept_cyc = cyc;
        #1 exp_q.push_back(expv);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
    endtask

    task automatic send_model(input logic [DW-1:0] tex, input logic [DW-1:0] vtx, input logic raw);
        send(tex, vtx, raw, model(tex, vtx, raw));
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.i_ready = 1'b1;
        while ((exp_q.size() != 0 || o_busy) && n < 100) begin
            n++;
            @(posedge clk);
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        i_rst        = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_tex    = '0;
        bus.i_vtx    = '0;
        bus.i_rawTex = 1'b0;
        bus.i_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_col", bus.o_col, '0);
        check("rst_busy", o_busy, 1'b0);
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.o_ready, 1'b1);
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Identity vertex colour, with latency measurement.
        first_valid_cyc = -1;
        send(24'h102030, 24'h808080, 1'b0, {9'h010, 9'h020, 9'h030});
        drain();
        check("latency", first_valid_cyc - accept_cyc, 2);

        // Range corners.
        send(24'hFFFFFF, 24'hFFFFFF, 1'b0, {3{9'h1FC}});
        send(24'h000000, 24'hFFFFFF, 1'b0, {3{9'h000}});
        send(24'hFFFFFF, 24'h010101, 1'b0, {3{9'h001}});
        send(24'hFFFFFF, 24'h808080, 1'b0, {3{9'h0FF}});
        send(24'h7F4001, 24'h02FF80, 1'b0, {9'h001, 9'h07F, 9'h001});
        // Raw texel bypass ignores the vertex colour.
        send(24'hABABAB, 24'h000000, 1'b1, {3{9'h0AB}});
        send(24'hFFFFFF, 24'hFFFFFF, 1'b1, {3{9'h0FF}});
        drain();

        // Eight pixels with downstream stalled on cycles 3..6.
        fork
            for (int i = 0; i < 8; i++) send_model(DW'($urandom), DW'($urandom), 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 bus.i_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.i_ready = 1'b1;
            end
        join
        drain();

        // Sixteen back-to-back pixels must come out on sixteen consecutive cycles.
        max_run = 0;
        for (int i = 0; i < 16; i++) send_model(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 3) == 0));
        drain();
        check("stream_run", max_run, 16);

        // Random traffic with random backpressure.
        fork
            for (int i = 0; i < 24; i++) send_model(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 4) == 0));
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 bus.i_ready = 1'($urandom_range(0, 1));
                end
                bus.i_ready = 1'b1;
            end
        join
        drain();

        // Fill both stages, then reset mid-operation.
        bus.i_ready = 1'b0;
        send_model(24'h112233, 24'h445566, 1'b0);
        send_model(24'h778899, 24'hAABBCC, 1'b0);
        @(posedge clk);
        #3;
        check("full_busy", o_busy, 1'b1);
        check("full_ready", bus.o_ready, 1'b0);
        mon_en = 1'b0;
        i_rst  = 1'b1;
        #1;
        check("midrst_valid", bus.o_valid, 1'b0);
        check("midrst_busy", o_busy, 1'b0);
        exp_q.delete();
        stall_prev  = 1'b0;
        run_len     = 0;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", bus.o_valid, 1'b0);
        send(24'h102030, 24'h808080, 1'b0, {9'h010, 9'h020, 9'h030});
        drain();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
